// File: rtl/dense_argmax_if.sv
// Score-stream and result-handshake bundle for dense_argmax.
// The slave modport belongs to the argmax block. The master modport belongs to whatever drives the scores and reads the result.
interface dense_argmax_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CLASS  = 7
);
    localparam int IDX_WIDTH = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic [IDX_WIDTH-1:0]  class_o;
    logic [DATA_WIDTH-1:0] score_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  busy_o;
    logic                  drop_o;
    logic                  err_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        output class_o, score_o, valid_o, busy_o, drop_o, err_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  class_o, score_o, valid_o, busy_o, drop_o, err_o
    );
endinterface

// File: rtl/dense_argmax.sv
// Running signed argmax over a serial vector of NUM_CLASS scores, with a one-deep result buffer.
// Defining DENSE_ARGMAX_TIMEOUT_EN adds an inter-score gap timeout that aborts partial vectors.
module dense_argmax #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CLASS      = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    dense_argmax_if.slave bus
);
    localparam int IDX_WIDTH = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

    if (NUM_CLASS < 1 || NUM_CLASS > 256 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("dense_argmax: illegal NUM_CLASS or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [IDX_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] max_reg, max_next;
    logic [IDX_WIDTH-1:0]  idx_reg, idx_next;
    logic [IDX_WIDTH-1:0]  class_reg, class_next;
    logic [DATA_WIDTH-1:0] score_reg, score_next;
    logic                  drop_reg, drop_next;
    logic                  err_reg, err_next;
    logic                  load_first;
    logic                  timeout;

`ifdef DENSE_ARGMAX_TIMEOUT_EN
    localparam int GAP_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_WIDTH-1:0] GAP_LIMIT = GAP_WIDTH'(TIMEOUT_CYCLES);
    logic [GAP_WIDTH-1:0] gap_reg;

    // Counts idle cycles since the last accepted score while a vector is open.
    always_ff @(posedge clk) begin
        if (rst || state_reg != ACCUM || timeout || bus.valid_i)
            gap_reg <= '0;
        else
            gap_reg <= gap_reg + GAP_WIDTH'(1);
    end

    assign timeout = (state_reg == ACCUM) && (gap_reg == GAP_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        max_next   = max_reg;
        idx_next   = idx_reg;
        class_next = class_reg;
        score_next = score_reg;
        drop_next  = drop_reg;
        err_next   = 1'b0;
        load_first = 1'b0;

        case (state_reg)
            IDLE: load_first = bus.valid_i;
            ACCUM: begin
                if (timeout) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                    load_first = bus.valid_i;
                end else if (bus.valid_i) begin
                    // Strict compare: ties keep the earlier index.
                    if ($signed(bus.data_i) > $signed(max_reg)) begin
                        max_next = bus.data_i;
                        idx_next = cnt_reg;
                    end
                    if (cnt_reg == LAST_IDX) begin
                        class_next = ($signed(bus.data_i) > $signed(max_reg)) ? cnt_reg : idx_reg;
                        score_next = ($signed(bus.data_i) > $signed(max_reg)) ? bus.data_i : max_reg;
                        state_next = HOLD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + IDX_WIDTH'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.ready_i) begin
                    state_next = IDLE;
                    load_first = bus.valid_i;
                end else if (bus.valid_i) begin
                    drop_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // First score of a vector, from IDLE, HOLD-with-handshake or a timeout cycle.
        if (load_first) begin
            max_next = bus.data_i;
            idx_next = '0;
            if (NUM_CLASS == 1) begin
                state_next = HOLD;
                cnt_next   = '0;
                class_next = '0;
                score_next = bus.data_i;
            end else begin
                state_next = ACCUM;
                cnt_next   = IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            max_reg   <= '0;
            idx_reg   <= '0;
            class_reg <= '0;
            score_reg <= '0;
            drop_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            max_reg   <= max_next;
            idx_reg   <= idx_next;
            class_reg <= class_next;
            score_reg <= score_next;
            drop_reg  <= drop_next;
            err_reg   <= err_next;
        end
    end

    assign bus.class_o = class_reg;
    assign bus.score_o = score_reg;
    assign bus.valid_o = (state_reg == HOLD);
    assign bus.busy_o  = (state_reg == ACCUM);
    assign bus.drop_o  = drop_reg;
    assign bus.err_o   = err_reg;
endmodule

// File: tb/tb_dense_argmax.sv
// Directed-vector self-checking bench for dense_argmax (DATA_WIDTH=8, NUM_CLASS=7, TIMEOUT_CYCLES=16).
module tb_dense_argmax;
    localparam int DW = 8;
    localparam int NC = 7;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   err_cnt;

    dense_argmax_if #(.DATA_WIDTH(DW), .NUM_CLASS(NC)) bus ();

    dense_argmax #(.DATA_WIDTH(DW), .NUM_CLASS(NC), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.err_o === 1'b1) err_cnt++;
    endtask

    task automatic put(input logic [7:0] d);
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
    endtask

    task automatic put7(input logic [7:0] a, b, c, d, e, f, g);
        put(a); put(b); put(c); put(d); put(e); put(f); put(g);
    endtask

    task automatic check_result(input string tag, input logic [31:0] cls, input logic [31:0] sc);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check({tag, "_class"}, 32'(bus.class_o), cls);
        check({tag, "_score"}, 32'(bus.score_o), sc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        err_cnt     = 0;
        rst         = 1'b1;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_class", 32'(bus.class_o), 32'd0);
        check("rst_score", 32'(bus.score_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_busy",  32'(bus.busy_o),  32'd0);
        check("rst_drop",  32'(bus.drop_o),  32'd0);
        check("rst_err",   32'(bus.err_o),   32'd0);

        // Mixed vector, tie at the max keeps index 2
        bus.ready_i = 1'b1;
        put(8'h0A);
        check("v1_busy", 32'(bus.busy_o), 32'd1);
        put(8'hFB); put(8'h28); put(8'h28); put(8'h03); put(8'h80);
        check("v1_novalid", 32'(bus.valid_o), 32'd0);
        put(8'h27);
        check_result("v1", 32'd2, 32'h28);
        tick();
        check("v1_drop_valid", 32'(bus.valid_o), 32'd0);
        check("v1_keep_class", 32'(bus.class_o), 32'd2);

        // Extremes
        put7(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        check_result("v2_min", 32'd0, 32'h80);
        tick();
        put7(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F);
        check_result("v3_max", 32'd6, 32'h7F);
        tick();

        // Scores arriving while the result is pending are dropped
        bus.ready_i = 1'b0;
        put7(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
        check_result("v4", 32'd6, 32'h07);
        put(8'h50);
        check("v4_drop1", 32'(bus.drop_o), 32'd1);
        put(8'h50);
        check_result("v4_hold", 32'd6, 32'h07);
        check("v4_drop2", 32'(bus.drop_o), 32'd1);
        bus.ready_i = 1'b1;
        tick();
        check("v4_release", 32'(bus.valid_o), 32'd0);
        check("v4_sticky", 32'(bus.drop_o), 32'd1);

        // Handshake and first score of the next vector on the same cycle
        bus.ready_i = 1'b0;
        put7(8'h09, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        check_result("v5", 32'd0, 32'h09);
        bus.ready_i = 1'b1;
        put(8'h05);
        check("v6_valid", 32'(bus.valid_o), 32'd0);
        check("v6_busy",  32'(bus.busy_o),  32'd1);
        check("v6_keep_score", 32'(bus.score_o), 32'h09);
        for (int i = 0; i < 6; i++) put(8'h01);
        check_result("v6", 32'd0, 32'h05);
        tick();

        // Reset mid-vector discards it
        put(8'h7F); put(8'h7E); put(8'h10); put(8'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_class", 32'(bus.class_o), 32'd0);
        check("mrst_score", 32'(bus.score_o), 32'd0);
        check("mrst_valid", 32'(bus.valid_o), 32'd0);
        check("mrst_busy",  32'(bus.busy_o),  32'd0);
        check("mrst_drop",  32'(bus.drop_o),  32'd0);
        put(8'hFD); put(8'hFE); put(8'hFF); put(8'hFF); put(8'hF7); put(8'h9C);
        check("v7_novalid", 32'(bus.valid_o), 32'd0);
        put(8'hFE);
        check_result("v7", 32'd2, 32'hFF);
        tick();

        // Long idle gap inside a vector
        err_cnt = 0;
        put(8'h0A); put(8'h14); put(8'h1E);
        for (int i = 0; i < 20; i++) tick();
        check("gap_valid", 32'(bus.valid_o), 32'd0);
`ifdef DENSE_ARGMAX_TIMEOUT_EN
        check("gap_busy", 32'(bus.busy_o), 32'd0);
        check("gap_err_pulses", 32'(err_cnt), 32'd1);
        put7(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
        check_result("v8", 32'd6, 32'h07);
`else
        check("gap_busy", 32'(bus.busy_o), 32'd1);
        check("gap_err_pulses", 32'(err_cnt), 32'd0);
        put(8'h28); put(8'h05); put(8'h05); put(8'h05);
        check_result("v8", 32'd3, 32'h28);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dense_argmax.md
Name: dense_argmax

Overview:
- Final classification stage, directly downstream of densedense.
- Consumes the serial stream of NUM_CLASS signed class scores on data_o/valid_o, tracks the running maximum, and presents the winning class index and score.
- Output uses a valid/ready handshake toward the result/readout logic.
- Buffers exactly one result; detects scores that arrive while the result is still pending.

Parameters:
- DATA_WIDTH, 8, score width; two's-complement signed.
- NUM_CLASS, 7, scores per inference vector; legal range 1..256.
- TIMEOUT_CYCLES, 1024, maximum idle gap between scores of one vector (used only with the optional feature).
- Localparam IDX_WIDTH = max(1, $clog2(NUM_CLASS)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_i  in  DATA_WIDTH  class score (signed), sampled when valid_i=1.
- valid_i  in  1  single-cycle score strobe; no backpressure toward upstream.
- class_o  out  IDX_WIDTH  index of the maximum score.
- score_o  out  DATA_WIDTH  maximum score value.
- valid_o  out  1  result valid; held until accepted.
- ready_i  in  1  downstream accept; transfer occurs when valid_o && ready_i.
- busy_o  out  1  high in ACCUM (partial vector collected).
- drop_o  out  1  sticky: a score arrived in HOLD without ready_i; cleared only by rst.
- err_o  out  1  one-cycle timeout-abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset (rst=1 at the clock edge): state=IDLE, cnt=0, max registers=0.
  - All outputs 0: class_o, score_o, valid_o, busy_o, drop_o, err_o.
  - rst overrides everything, including mid-vector and HOLD; a partial vector or pending result is discarded silently.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - On valid_i: load max=data_i, idx=0, cnt=1.
  - Go to ACCUM, or to HOLD if NUM_CLASS==1.
- ACCUM:
  - On valid_i: if $signed(data_i) > $signed(max), load max=data_i, idx=cnt.
  - Comparison is strict, so ties keep the lower index.
  - cnt increments; when the accepted score is number NUM_CLASS-1 (last), go to HOLD and reset cnt to 0.
  - Cycles with valid_i=0 hold state.
- HOLD:
  - valid_o=1; class_o and score_o stable and equal to the final max registers.
  - ready_i=1 with valid_i=0: go to IDLE next cycle; valid_o falls.
  - ready_i=1 with valid_i=1 in the same cycle: the result is consumed and data_i is accepted as score 0 of the next vector (IDLE-load rule applied). Next state is ACCUM, or HOLD for NUM_CLASS==1. No score is lost.
  - valid_i=1 with ready_i=0: score dropped, drop_o set (sticky), state unchanged.
- Latency: valid_o rises the cycle after the clock edge that accepts the last score. Back-to-back vectors are supported when ready_i is held high.
- class_o and score_o update only when a vector completes; they keep their last values after the handshake until the next completion.
- Scores arrive at most one per cycle.
- Values at the extremes (-128 and +127 for DATA_WIDTH=8) compare correctly as signed.

Optional Feature:
- Macro: DENSE_ARGMAX_TIMEOUT_EN.
- Defined:
  - In ACCUM, a gap counter clears on each valid_i and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, cnt=0, err_o=1 for one cycle.
  - The partial vector is discarded; valid_o is not asserted.
  - A valid_i arriving on the same cycle as the timeout is treated as score 0 of a new vector.
- Undefined: no gap counter is built; ACCUM waits indefinitely; err_o=0 constantly.

Test Plan:
- Reset, ready_i=1, stream scores 10,-5,40,40,3,-128,39 (hex 0A,FB,28,28,03,80,27) -> one cycle after the 7th strobe: valid_o=1, class_o=2, score_o=0x28; valid_o drops one cycle later.
- All seven scores 0x80 -> class_o=0, score_o=0x80. Then scores 0x7F at index 6, all others 0x00 -> class_o=6, score_o=0x7F.
- Hold ready_i=0 after completion, then pulse valid_i twice -> valid_o stays 1, outputs unchanged, drop_o=1 and stays 1. Raise ready_i -> valid_o falls; drop_o remains 1 until rst.
- Complete a vector, then drive ready_i=1 and valid_i=1 with data 0x05 on the same cycle -> handshake completes, busy_o=1, a new vector starts with max=0x05, idx=0. Finish with six scores of 0x01 -> class_o=0, score_o=0x05.
- Send 4 scores, then assert rst for 1 cycle, then send 7 fresh scores -> all outputs 0 after reset. The result reflects only the fresh 7 scores; no valid_o for the aborted vector.
- With DENSE_ARGMAX_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 3 scores, then idle 16 cycles -> err_o pulses once, busy_o=0, valid_o never rises. A following full vector completes normally.
